imm_gen_pipe: RTL

- Parametrised, pipelined successor to the combinational immediate generator.
- Decodes the full RV32I/RV64I immediate set: I, S, B, U, J and shift-amount forms.
- Sign-extends each immediate to XLEN and classifies the instruction format.
- Sits between instruction fetch/decode and the ID/EX register; uses valid/ready handshakes on both sides and a 2-entry skid buffer, so ready paths are fully registered.

---
 rtl/imm_gen_pipe.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator with one register stage and a 2-entry skid buffer.
// Decode is combinational on instr_i; main register drives the outputs, skid absorbs one stall.
module imm_gen_pipe #(
    parameter int XLEN    = 64,
    parameter bit EN_RV64 = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o
);

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ILL   = 3'd7
    } fmt_e;

    typedef struct packed {
        fmt_e                   fmt;
        logic signed [XLEN-1:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [2:0] f3;
        d.fmt = FMT_ILL;
        d.imm = '0;
        f3    = ins[14:12];
        case (ins[6:0])
            7'b0000011, 7'b1100111: begin
                d.fmt = FMT_I;
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.fmt = FMT_SHAMT;
                    if (EN_RV64) d.imm = {{(XLEN-6){1'b0}}, ins[25:20]};
                    else         d.imm = {{(XLEN-5){1'b0}}, ins[24:20]};
                end else begin
                    d.fmt = FMT_I;
                    d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
                end
            end
            7'b0011011: begin
                // Word-sized immediates; funct3 values outside 000/001/101 stay illegal.
                if (EN_RV64) begin
                    if (f3 == 3'b000) begin
                        d.fmt = FMT_I;
                        d.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
                    end else if (f3 == 3'b001 || f3 == 3'b101) begin
                        d.fmt = FMT_SHAMT;
                        d.imm = {{(XLEN-5){1'b0}}, ins[24:20]};
                    end
                end
            end
            7'b0100011: begin
                d.fmt = FMT_S;
                d.imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                d.fmt = FMT_B;
                d.imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d.fmt = FMT_U;
                d.imm = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
            end
            7'b1101111: begin
                d.fmt = FMT_J;
                d.imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                d.fmt = FMT_R;
                d.imm = '0;
            end
            default: begin
                d.fmt = FMT_ILL;
                d.imm = '0;
            end
        endcase
        return d;
    endfunction

    logic            main_valid_q, main_valid_d;
    logic [XLEN-1:0] main_imm_q,   main_imm_d;
    logic [2:0]      main_fmt_q,   main_fmt_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic [2:0]      skid_fmt_q,   skid_fmt_d;

    dec_t dec;
    logic accept;
    logic drain;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign imm_o       = main_imm_q;
    assign fmt_o       = main_fmt_q;

    assign accept = in_valid_i & ~skid_valid_q;
    assign drain  = main_valid_q & out_ready_i;

    always_comb begin
        dec          = decode(instr_i);
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_fmt_d   = main_fmt_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        if (flush_i) begin
            // Data registers keep their contents; only the valid bits are dropped.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_fmt_d   = skid_fmt_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_valid_d = 1'b1;
                main_imm_d   = dec.imm;
                main_fmt_d   = dec.fmt;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec.imm;
                skid_fmt_d   = dec.fmt;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_fmt_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
        end
    end

    // Skid payload is only ever read behind skid_valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        skid_imm_q <= skid_imm_d;
        skid_fmt_q <= skid_fmt_d;
    end

endmodule
